fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready port,
// buffers one instruction for IF/ID and squashes on branch/jump redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = fetch_unit_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP
) (
    input  logic        clk,
    input  logic        startin,
    input  logic        PCWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_instr,
    output logic [31:0] IF_pc_plus_4,
    output logic        IF_valid
);
    import fetch_unit_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] pc4_q, pc4_d;
    logic        redirect;
    logic [31:0] target;

    assign redirect = branch_taken | jump;
    assign target   = (branch_taken ? branch_target : jump_target) & ~32'h3;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ibuf_d  = ibuf_q;
        pc4_d   = pc4_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = imem_ready ? S_REQ : S_DRAIN;
                end else if (imem_ready) begin
                    ibuf_d  = imem_rdata;
                    pc4_d   = pc_q + 32'd4;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (PCWrite) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d = target;
                end
                if (imem_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The request address only moves when a new request starts, so a
        // draining request keeps its original address while pc is redirected.
        if (state_d == S_REQ) begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (startin) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            ibuf_q  <= NOP_INSTR;
            pc4_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ibuf_q  <= ibuf_d;
            pc4_q   <= pc4_d;
        end
    end

    assign imem_req     = (state_q == S_REQ) || (state_q == S_DRAIN);
    assign imem_addr    = addr_q;
    assign IF_valid     = (state_q == S_HOLD);
    assign IF_instr     = IF_valid ? ibuf_q : NOP_INSTR;
    assign IF_pc_plus_4 = IF_valid ? pc4_q : '0;

endmodule
